// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM arbiter: FSM state encoding,
// requester ids and the legal range of the per-access cycle count.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_TURN = 2'd3
    } state_t;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_VID = 1'b1
    } req_id_t;

    localparam int ACCESS_CYCLES_MIN = 2;
    localparam int ACCESS_CYCLES_MAX = 7;
    localparam int CNT_W             = 3;
    localparam int DATA_W            = 8;

endpackage

// File: rtl/sram_arb_req_latch.sv
// Single-entry pending slot for CPU bus strobes plus the sticky overflow flag.
// A simultaneous rd+wr strobe is stored as a write.
module sram_arb_req_latch
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    input  logic              grant,
    output logic              pend,
    output logic              pend_wr,
    output logic [ADDR_W-1:0] pend_addr,
    output logic [DATA_W-1:0] pend_data,
    output logic              ovf
);

    logic strobe;
    logic accept;

    assign strobe = cpu_rd | cpu_wr;
    // The slot empties on the grant edge, so a strobe landing on that same edge still fits.
    assign accept = strobe & (~pend | grant);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            if (accept) begin
                pend <= 1'b1;
            end else if (grant) begin
                pend <= 1'b0;
            end
            if (strobe && !accept) begin
                ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pend_wr   <= cpu_wr;
            pend_addr <= cpu_addr;
            pend_data <= cpu_data;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one async SRAM between the CPU bus and the video
// fetch port; owns OE/WE/direction timing. Define SRAM_ARB_TURN_EN for a turnaround cycle after writes.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ACCESS_CYCLES = 2,
    parameter int ADDR_W        = 20
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic              iCpuRd,
    input  logic              iCpuWr,
    input  logic [ADDR_W-1:0] iCpuAddr,
    input  logic [DATA_W-1:0] iCpuData,
    output logic [DATA_W-1:0] oCpuData,
    output logic              oCpuDone,
    output logic              oCpuOvf,
    input  logic              iVidReq,
    input  logic [ADDR_W-1:0] iVidAddr,
    output logic              oVidAck,
    output logic [DATA_W-1:0] oVidData,
    output logic [ADDR_W-1:0] oSramA,
    output logic [DATA_W-1:0] oSramD,
    input  logic [DATA_W-1:0] iSramD,
    output logic              oSramDir,
    output logic              oSramOe,
    output logic              oSramWe
);

    if (ACCESS_CYCLES < ACCESS_CYCLES_MIN || ACCESS_CYCLES > ACCESS_CYCLES_MAX) begin : g_bad_access_cycles
        $error("sram_arbiter: ACCESS_CYCLES out of range");
    end

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACCESS_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t              state, state_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx, cnt_inc;
    req_id_t             cur_id, cur_id_nx;
    req_id_t             last_grant, last_grant_nx;
    logic [ADDR_W-1:0]   sram_a_nx;
    logic [DATA_W-1:0]   sram_d_nx;
    logic                dir_nx, oe_nx, we_nx;
    logic [DATA_W-1:0]   cpu_data_nx, vid_data_nx;
    logic                cpu_done_nx, vid_ack_nx;

    logic                pend, pend_wr, cpu_grant;
    logic [ADDR_W-1:0]   pend_addr;
    logic [DATA_W-1:0]   pend_data;

    sram_arb_req_latch #(
        .ADDR_W (ADDR_W)
    ) u_req_latch (
        .clk       (iClk),
        .rst       (iReset),
        .cpu_rd    (iCpuRd),
        .cpu_wr    (iCpuWr),
        .cpu_addr  (iCpuAddr),
        .cpu_data  (iCpuData),
        .grant     (cpu_grant),
        .pend      (pend),
        .pend_wr   (pend_wr),
        .pend_addr (pend_addr),
        .pend_data (pend_data),
        .ovf       (oCpuOvf)
    );

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        cur_id_nx     = cur_id;
        last_grant_nx = last_grant;
        sram_a_nx     = oSramA;
        sram_d_nx     = oSramD;
        dir_nx        = 1'b0;
        oe_nx         = 1'b1;
        we_nx         = 1'b1;
        cpu_data_nx   = oCpuData;
        vid_data_nx   = oVidData;
        cpu_done_nx   = 1'b0;
        vid_ack_nx    = 1'b0;
        cpu_grant     = 1'b0;
        cnt_inc       = cnt + CNT_ONE;

        case (state)
            ST_IDLE: begin
                // CPU wins unless video is also waiting and CPU had the last turn.
                if (pend && (!iVidReq || last_grant == REQ_VID)) begin
                    cpu_grant     = 1'b1;
                    cur_id_nx     = REQ_CPU;
                    last_grant_nx = REQ_CPU;
                    cnt_nx        = CNT_ONE;
                    sram_a_nx     = pend_addr;
                    if (pend_wr) begin
                        state_nx  = ST_WR;
                        sram_d_nx = pend_data;
                        dir_nx    = 1'b1;
                        we_nx     = 1'b0;
                    end else begin
                        state_nx  = ST_RD;
                        oe_nx     = 1'b0;
                    end
                end else if (iVidReq) begin
                    cur_id_nx     = REQ_VID;
                    last_grant_nx = REQ_VID;
                    cnt_nx        = CNT_ONE;
                    sram_a_nx     = iVidAddr;
                    state_nx      = ST_RD;
                    oe_nx         = 1'b0;
                end
            end
            ST_RD: begin
                if (cnt == LAST_CNT) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                    if (cur_id == REQ_CPU) begin
                        cpu_data_nx = iSramD;
                        cpu_done_nx = 1'b1;
                    end else begin
                        vid_data_nx = iSramD;
                        vid_ack_nx  = 1'b1;
                    end
                end else begin
                    cnt_nx = cnt_inc;
                    oe_nx  = 1'b0;
                end
            end
            ST_WR: begin
                if (cnt == LAST_CNT) begin
`ifdef SRAM_ARB_TURN_EN
                    state_nx    = ST_TURN;
`else
                    state_nx    = ST_IDLE;
`endif
                    cnt_nx      = '0;
                    cpu_done_nx = 1'b1;
                end else begin
                    cnt_nx = cnt_inc;
                    dir_nx = 1'b1;
                    // WE rises in the final cycle so address and data outlast it.
                    we_nx  = (cnt_inc == LAST_CNT);
                end
            end
`ifdef SRAM_ARB_TURN_EN
            ST_TURN: begin
                state_nx = ST_IDLE;
            end
`endif
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            cur_id     <= REQ_CPU;
            last_grant <= REQ_VID;
            oSramA     <= '0;
            oSramD     <= '0;
            oSramDir   <= 1'b0;
            oSramOe    <= 1'b1;
            oSramWe    <= 1'b1;
            oCpuData   <= '0;
            oVidData   <= '0;
            oCpuDone   <= 1'b0;
            oVidAck    <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            cur_id     <= cur_id_nx;
            last_grant <= last_grant_nx;
            oSramA     <= sram_a_nx;
            oSramD     <= sram_d_nx;
            oSramDir   <= dir_nx;
            oSramOe    <= oe_nx;
            oSramWe    <= we_nx;
            oCpuData   <= cpu_data_nx;
            oVidData   <= vid_data_nx;
            oCpuDone   <= cpu_done_nx;
            oVidAck    <= vid_ack_nx;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural async SRAM model.
module tb_sram_arbiter;

    logic        iClk = 1'b0;
    logic        iReset;
    logic        iCpuRd, iCpuWr;
    logic [19:0] iCpuAddr, iVidAddr;
    logic [7:0]  iCpuData;
    logic [7:0]  oCpuData, oVidData, oSramD, iSramD;
    logic        oCpuDone, oCpuOvf, iVidReq, oVidAck;
    logic [19:0] oSramA;
    logic        oSramDir, oSramOe, oSramWe;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  mem [0:1048575];
    logic [20:0] glog [$];
    int          vid_acks = 0;
    logic [7:0]  vid_last = 8'h00;
    logic        prev_oe = 1'b1;
    logic        prev_dir = 1'b0;
    logic [7:0]  rdat;

    sram_arbiter #(
        .ACCESS_CYCLES (2),
        .ADDR_W        (20)
    ) dut (
        .iClk     (iClk),
        .iReset   (iReset),
        .iCpuRd   (iCpuRd),
        .iCpuWr   (iCpuWr),
        .iCpuAddr (iCpuAddr),
        .iCpuData (iCpuData),
        .oCpuData (oCpuData),
        .oCpuDone (oCpuDone),
        .oCpuOvf  (oCpuOvf),
        .iVidReq  (iVidReq),
        .iVidAddr (iVidAddr),
        .oVidAck  (oVidAck),
        .oVidData (oVidData),
        .oSramA   (oSramA),
        .oSramD   (oSramD),
        .iSramD   (iSramD),
        .oSramDir (oSramDir),
        .oSramOe  (oSramOe),
        .oSramWe  (oSramWe)
    );

    always #50 iClk = ~iClk;

    // Async SRAM: drives data while OE is low, latches on the rising WE.
    assign iSramD = oSramOe ? 8'hEE : mem[oSramA];

    always @(posedge oSramWe) begin
        if (!iReset && oSramDir) mem[oSramA] = oSramD;
    end

    // Access-start log and video ack monitor.
    always @(negedge iClk) begin
        if (iReset) begin
            prev_oe  = 1'b1;
            prev_dir = 1'b0;
        end else begin
            if ((!oSramOe && prev_oe) || (oSramDir && !prev_dir)) glog.push_back({oSramDir, oSramA});
            if (oVidAck) begin
                vid_acks++;
                vid_last = oVidData;
            end
            prev_oe  = oSramOe;
            prev_dir = oSramDir;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic do_reset();
        iReset = 1'b1;
        step();
        step();
        iReset = 1'b0;
        glog.delete();
        vid_acks = 0;
        step();
    endtask

    task automatic cpu_access(input logic wr, input logic [19:0] a, input logic [7:0] d,
                              output logic [7:0] rd);
        iCpuRd = ~wr;
        iCpuWr = wr;
        iCpuAddr = a;
        iCpuData = d;
        step();
        iCpuRd = 1'b0;
        iCpuWr = 1'b0;
        for (int i = 0; i < 20 && !oCpuDone; i++) step();
        chk($sformatf("done_%05h", a), 32'(oCpuDone), 32'd1);
        rd = oCpuData;
    endtask

    initial begin
        logic [20:0] exp_log [6];
        logic [7:0]  exp_rd [3];
        logic [19:0] rd_addr [3];

        iReset = 1'b0; iCpuRd = 1'b0; iCpuWr = 1'b0; iCpuAddr = '0; iCpuData = '0;
        iVidReq = 1'b0; iVidAddr = '0;
        mem[20'h12345] = 8'hA5;
        mem[20'hB0000] = 8'h77;
        mem[20'h00010] = 8'h11;
        mem[20'h00020] = 8'h22;
        mem[20'h00030] = 8'h33;

        // Reset values
        #10 iReset = 1'b1;
        step();
        step();
        chk("rst_oe",    32'(oSramOe),  32'd1);
        chk("rst_we",    32'(oSramWe),  32'd1);
        chk("rst_dir",   32'(oSramDir), 32'd0);
        chk("rst_a",     32'(oSramA),   32'd0);
        chk("rst_d",     32'(oSramD),   32'd0);
        chk("rst_cdata", 32'(oCpuData), 32'd0);
        chk("rst_vdata", 32'(oVidData), 32'd0);
        chk("rst_done",  32'(oCpuDone), 32'd0);
        chk("rst_ack",   32'(oVidAck),  32'd0);
        chk("rst_ovf",   32'(oCpuOvf),  32'd0);
        iReset = 1'b0;
        step();

        // CPU read on idle bus
        iCpuRd = 1'b1; iCpuAddr = 20'h12345;
        step();
        iCpuRd = 1'b0;
        chk("rd_c1_oe", 32'(oSramOe), 32'd1);
        step();
        chk("rd_c2_oe",  32'(oSramOe),  32'd0);
        chk("rd_c2_a",   32'(oSramA),   32'h12345);
        chk("rd_c2_dir", 32'(oSramDir), 32'd0);
        chk("rd_c2_we",  32'(oSramWe),  32'd1);
        step();
        chk("rd_c3_oe",   32'(oSramOe),  32'd0);
        chk("rd_c3_done", 32'(oCpuDone), 32'd0);
        step();
        chk("rd_c4_done", 32'(oCpuDone), 32'd1);
        chk("rd_c4_data", 32'(oCpuData), 32'hA5);
        chk("rd_c4_oe",   32'(oSramOe),  32'd1);
        step();
        chk("rd_c5_done", 32'(oCpuDone), 32'd0);
        chk("rd_c5_data", 32'(oCpuData), 32'hA5);

        // CPU write, WE low one cycle, then readback
        iCpuWr = 1'b1; iCpuAddr = 20'hFE010; iCpuData = 8'h3C;
        step();
        iCpuWr = 1'b0;
        chk("wr_c1_dir", 32'(oSramDir), 32'd0);
        step();
        chk("wr_c2_we",  32'(oSramWe),  32'd0);
        chk("wr_c2_dir", 32'(oSramDir), 32'd1);
        chk("wr_c2_a",   32'(oSramA),   32'hFE010);
        chk("wr_c2_d",   32'(oSramD),   32'h3C);
        chk("wr_c2_oe",  32'(oSramOe),  32'd1);
        step();
        chk("wr_c3_we",  32'(oSramWe),  32'd1);
        chk("wr_c3_dir", 32'(oSramDir), 32'd1);
        chk("wr_c3_a",   32'(oSramA),   32'hFE010);
        chk("wr_c3_d",   32'(oSramD),   32'h3C);
        step();
        chk("wr_c4_dir",  32'(oSramDir), 32'd0);
        chk("wr_c4_done", 32'(oCpuDone), 32'd1);
        chk("wr_mem",     32'(mem[20'hFE010]), 32'h3C);
        cpu_access(1'b0, 20'hFE010, 8'h00, rdat);
        chk("wr_readback", 32'(rdat), 32'h3C);
        step();
        step();

        // Write immediately followed by read: turnaround behaviour
        iCpuWr = 1'b1; iCpuAddr = 20'h00100; iCpuData = 8'h5C;
        step();
        iCpuWr = 1'b0;
        step();
        iCpuRd = 1'b1; iCpuAddr = 20'h00100;
        step();
        iCpuRd = 1'b0;
        step();
        chk("ta_c4_oe",   32'(oSramOe),  32'd1);
        chk("ta_c4_we",   32'(oSramWe),  32'd1);
        chk("ta_c4_dir",  32'(oSramDir), 32'd0);
        chk("ta_c4_done", 32'(oCpuDone), 32'd1);
        step();
`ifdef SRAM_ARB_TURN_EN
        chk("ta_c5_oe",  32'(oSramOe),  32'd1);
        chk("ta_c5_we",  32'(oSramWe),  32'd1);
        chk("ta_c5_dir", 32'(oSramDir), 32'd0);
        step();
        chk("ta_c6_oe",  32'(oSramOe),  32'd0);
        step();
        step();
`else
        chk("ta_c5_oe",  32'(oSramOe),  32'd0);
        chk("ta_c5_dir", 32'(oSramDir), 32'd0);
        step();
        step();
`endif
        chk("ta_rd_done", 32'(oCpuDone), 32'd1);
        chk("ta_rd_data", 32'(oCpuData), 32'h5C);
        step();

        // Reset asserted in the middle of a write
        iCpuWr = 1'b1; iCpuAddr = 20'h22222; iCpuData = 8'h99;
        step();
        iCpuWr = 1'b0;
        step();
        chk("mrst_pre_we", 32'(oSramWe), 32'd0);
        #20 iReset = 1'b1;
        #1;
        chk("mrst_we",   32'(oSramWe),  32'd1);
        chk("mrst_oe",   32'(oSramOe),  32'd1);
        chk("mrst_dir",  32'(oSramDir), 32'd0);
        chk("mrst_done", 32'(oCpuDone), 32'd0);
        step();
        iReset = 1'b0;
        step();
        cpu_access(1'b0, 20'h12345, 8'h00, rdat);
        chk("mrst_read", 32'(rdat), 32'hA5);

        // Contention: video held on, CPU reissues a read as each completes
        do_reset();
        rd_addr[0] = 20'h00010; rd_addr[1] = 20'h00020; rd_addr[2] = 20'h00030;
        exp_rd[0] = 8'h11; exp_rd[1] = 8'h22; exp_rd[2] = 8'h33;
        iCpuRd = 1'b1; iCpuAddr = rd_addr[0];
        step();
        iCpuRd = 1'b0;
        iVidReq = 1'b1; iVidAddr = 20'hB0000;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 20 && !oCpuDone; i++) step();
            chk($sformatf("ct_done%0d", k), 32'(oCpuDone), 32'd1);
            chk($sformatf("ct_data%0d", k), 32'(oCpuData), 32'(exp_rd[k]));
            if (k < 2) begin
                iCpuRd = 1'b1; iCpuAddr = rd_addr[k + 1];
            end
            step();
            iCpuRd = 1'b0;
        end
        iVidReq = 1'b0;
        repeat (8) step();
        exp_log[0] = {1'b0, 20'h00010};
        exp_log[1] = {1'b0, 20'hB0000};
        exp_log[2] = {1'b0, 20'h00020};
        exp_log[3] = {1'b0, 20'hB0000};
        exp_log[4] = {1'b0, 20'h00030};
        exp_log[5] = {1'b0, 20'hB0000};
        for (int i = 0; i < 6; i++) begin
            if (i < glog.size()) chk($sformatf("ct_grant%0d", i), 32'(glog[i]), 32'(exp_log[i]));
            else                 chk($sformatf("ct_grant%0d", i), 32'hFFFF_FFFF, 32'(exp_log[i]));
        end
        chk("ct_vid_acks", 32'(vid_acks), 32'd3);
        chk("ct_vid_data", 32'(vid_last), 32'h77);

        // Overflow: second strobe while the slot waits behind a video read
        do_reset();
        iVidReq = 1'b1; iVidAddr = 20'hB0000;
        step();
        iVidReq = 1'b0;
        iCpuRd = 1'b1; iCpuAddr = 20'h00010;
        step();
        iCpuAddr = 20'h00020;
        chk("ov_c2_ovf", 32'(oCpuOvf), 32'd0);
        step();
        iCpuRd = 1'b0;
        chk("ov_c3_ovf",  32'(oCpuOvf),  32'd1);
        chk("ov_c3_ack",  32'(oVidAck),  32'd1);
        chk("ov_c3_vdat", 32'(oVidData), 32'h77);
        step();
        chk("ov_c4_oe", 32'(oSramOe), 32'd0);
        chk("ov_c4_a",  32'(oSramA),  32'h00010);
        step();
        step();
        chk("ov_c6_done", 32'(oCpuDone), 32'd1);
        chk("ov_c6_data", 32'(oCpuData), 32'h11);
        begin
            int extra = 0;
            for (int i = 0; i < 8; i++) begin
                step();
                if (oCpuDone) extra++;
            end
            chk("ov_no_second", 32'(extra), 32'd0);
        end
        chk("ov_sticky", 32'(oCpuOvf), 32'd1);
        iReset = 1'b1;
        step();
        chk("ov_cleared", 32'(oCpuOvf), 32'd0);
        iReset = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
